// File: rtl/binary_adder_4bit.sv
// Registered carry-in/carry-out adder with one-cycle latency.
// Carry-lookahead inside 4-bit groups, group carries ripple between groups.
module binary_adder_4bit #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             Cin,
  output logic [WIDTH-1:0] Sum,
  output logic             Cout,
  output logic             Ovf,
  output logic             Zero,
  output logic             out_valid
);

  localparam int NG = WIDTH / 4;

  logic [WIDTH-1:0] g;
  logic [WIDTH-1:0] p;
  logic [WIDTH-1:0] c;
  logic [NG:0]      gc;

  assign g     = A & B;
  assign p     = A ^ B;
  assign gc[0] = Cin;

  for (genvar k = 0; k < NG; k++) begin : g_grp
    localparam int B0 = 4 * k;
    logic [3:0] gg;
    logic [3:0] pp;
    logic       ci;

    assign gg = g[B0 +: 4];
    assign pp = p[B0 +: 4];
    assign ci = gc[k];

    assign c[B0]   = ci;
    assign c[B0+1] = gg[0] | (pp[0] & ci);
    assign c[B0+2] = gg[1] | (pp[1] & gg[0])
                   | (pp[1] & pp[0] & ci);
    assign c[B0+3] = gg[2] | (pp[2] & gg[1])
                   | (pp[2] & pp[1] & gg[0])
                   | (pp[2] & pp[1] & pp[0] & ci);
    assign gc[k+1] = gg[3] | (pp[3] & gg[2])
                   | (pp[3] & pp[2] & gg[1])
                   | (pp[3] & pp[2] & pp[1] & gg[0])
                   | (pp[3] & pp[2] & pp[1] & pp[0] & ci);
  end

  logic [WIDTH-1:0] sum_d;
  logic             cout_d;
  logic             ovf_d;
  logic             zero_d;

  always_comb begin
    sum_d  = p ^ c;
    cout_d = gc[NG];
    // Signed overflow: like-signed operands, result sign differs
    ovf_d  = (A[WIDTH-1] == B[WIDTH-1]) &&
             (sum_d[WIDTH-1] != A[WIDTH-1]);
    zero_d = (sum_d == '0);
  end

  logic [WIDTH-1:0] sum_q;
  logic             cout_q;
  logic             ovf_q;
  logic             zero_q;
  logic             valid_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      sum_q   <= '0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
      zero_q  <= 1'b0;
      valid_q <= 1'b0;
    end else begin
      valid_q <= in_valid;
      if (in_valid) begin
        sum_q  <= sum_d;
        cout_q <= cout_d;
        ovf_q  <= ovf_d;
        zero_q <= zero_d;
      end
    end
  end

  assign Sum       = sum_q;
  assign Cout      = cout_q;
  assign Ovf       = ovf_q;
  assign Zero      = zero_q;
  assign out_valid = valid_q;

endmodule

// File: tb/tb_binary_adder_4bit.sv
// Bench for binary_adder_4bit: directed table, corner sequences,
// exhaustive 4-bit and random 16-bit against an arithmetic model.
module tb_binary_adder_4bit;

  logic        clk = 1'b0;
  logic        rst;
  logic        v4;
  logic [3:0]  a4, b4;
  logic        c4;
  logic [3:0]  s4;
  logic        co4, ov4, z4, ova4;
  logic        v16;
  logic [15:0] a16, b16;
  logic        c16;
  logic [15:0] s16;
  logic        co16, ov16, z16, ova16;

  int n_chk  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  binary_adder_4bit #(.WIDTH(4)) u_dut4 (
    .clk(clk), .rst(rst), .in_valid(v4),
    .A(a4), .B(b4), .Cin(c4),
    .Sum(s4), .Cout(co4), .Ovf(ov4),
    .Zero(z4), .out_valid(ova4)
  );

  binary_adder_4bit #(.WIDTH(16)) u_dut16 (
    .clk(clk), .rst(rst), .in_valid(v16),
    .A(a16), .B(b16), .Cin(c16),
    .Sum(s16), .Cout(co16), .Ovf(ov16),
    .Zero(z16), .out_valid(ova16)
  );

  typedef struct packed {
    logic [15:0] sum;
    logic        cout;
    logic        ovf;
    logic        zero;
  } res_t;

  typedef struct {
    logic [3:0] a;
    logic [3:0] b;
    logic       cin;
    logic [3:0] sum;
    logic       cout;
    logic       ovf;
    logic       zero;
  } vec_t;

  // Reference: plain integer addition, signed range check for overflow
  function automatic res_t model(int w, longint a, longint b, longint cin);
    res_t   r;
    longint m   = longint'(1) << w;
    longint h   = m >> 1;
    longint tot = a + b + cin;
    longint sa  = (a >= h) ? a - m : a;
    longint sb  = (b >= h) ? b - m : b;
    longint st  = sa + sb + cin;
    r.sum  = 16'(tot % m);
    r.cout = (tot >= m);
    r.ovf  = (st > h - 1) || (st < -h);
    r.zero = ((tot % m) == 0);
    return r;
  endfunction

  task automatic chk(string nm, longint act, longint exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drv4(logic v, logic [3:0] a, logic [3:0] b, logic c);
    v4 = v; a4 = a; b4 = b; c4 = c;
  endtask

  task automatic chk4(string nm, res_t e, logic vld);
    chk({nm, ".sum"},  s4,   e.sum);
    chk({nm, ".cout"}, co4,  e.cout);
    chk({nm, ".ovf"},  ov4,  e.ovf);
    chk({nm, ".zero"}, z4,   e.zero);
    chk({nm, ".vld"},  ova4, vld);
  endtask

  vec_t tbl[8];
  res_t e;
  res_t zr;

  initial begin
    tbl[0] = '{4'd6,  4'd9,  1'b0, 4'd15, 1'b0, 1'b0, 1'b0};
    tbl[1] = '{4'd3,  4'd3,  1'b1, 4'd7,  1'b0, 1'b0, 1'b0};
    tbl[2] = '{4'd4,  4'd5,  1'b0, 4'd9,  1'b0, 1'b1, 1'b0};
    tbl[3] = '{4'd9,  4'd7,  1'b0, 4'd0,  1'b1, 1'b0, 1'b1};
    tbl[4] = '{4'd11, 4'd12, 1'b1, 4'd8,  1'b1, 1'b0, 1'b0};
    tbl[5] = '{4'd15, 4'd15, 1'b1, 4'd15, 1'b1, 1'b0, 1'b0};
    tbl[6] = '{4'd0,  4'd0,  1'b0, 4'd0,  1'b0, 1'b0, 1'b1};
    tbl[7] = '{4'd8,  4'd8,  1'b0, 4'd0,  1'b1, 1'b1, 1'b1};
    zr = '0;

    rst = 1'b1;
    drv4(1'b1, 4'd15, 4'd15, 1'b1);
    v16 = 1'b1; a16 = 16'hffff; b16 = 16'hffff; c16 = 1'b1;
    for (int i = 0; i < 2; i++) begin
      tick();
      chk4("reset", zr, 1'b0);
      chk("reset16.sum", s16, 0);
      chk("reset16.vld", ova16, 0);
    end
    rst = 1'b0;
    v16 = 1'b0;

    for (int i = 0; i < 8; i++) begin
      drv4(1'b1, tbl[i].a, tbl[i].b, tbl[i].cin);
      tick();
      e.sum  = 16'(tbl[i].sum);
      e.cout = tbl[i].cout;
      e.ovf  = tbl[i].ovf;
      e.zero = tbl[i].zero;
      chk4($sformatf("vec%0d", i), e, 1'b1);
    end

    drv4(1'b1, 4'd4, 4'd5, 1'b0);
    tick();
    e = '{16'd9, 1'b0, 1'b1, 1'b0};
    chk4("hold.load", e, 1'b1);
    for (int i = 0; i < 3; i++) begin
      drv4(1'b0, 4'($urandom), 4'($urandom), 1'($urandom));
      tick();
      chk4($sformatf("hold%0d", i), e, 1'b0);
    end

    drv4(1'b1, 4'd6, 4'd9, 1'b0);
    tick();
    chk4("mid.pre", '{16'd15, 1'b0, 1'b0, 1'b0}, 1'b1);
    rst = 1'b1;
    drv4(1'b1, 4'd3, 4'd3, 1'b1);
    tick();
    chk4("mid.rst", zr, 1'b0);
    rst = 1'b0;
    drv4(1'b0, 4'd3, 4'd3, 1'b1);
    tick();
    chk4("mid.post", zr, 1'b0);

    for (int i = 0; i < 512; i++) begin
      drv4(1'b1, 4'(i), 4'(i >> 4), 1'(i >> 8));
      e = model(4, longint'(i & 15), longint'((i >> 4) & 15),
                longint'((i >> 8) & 1));
      tick();
      chk4($sformatf("exh%0d", i), e, 1'b1);
    end
    drv4(1'b0, 4'd0, 4'd0, 1'b0);

    for (int i = 0; i < 10000; i++) begin
      v16 = 1'b1;
      a16 = 16'($urandom);
      b16 = 16'($urandom);
      c16 = 1'($urandom);
      if (i == 0) begin
        a16 = 16'hffff; b16 = 16'hffff; c16 = 1'b1;
      end
      e = model(16, longint'(a16), longint'(b16), longint'(c16));
      tick();
      chk($sformatf("r16_%0d", i),
          {ova16, co16, ov16, z16, s16},
          {1'b1, e.cout, e.ovf, e.zero, e.sum});
    end
    v16 = 1'b0;
    tick();
    chk("r16.end.vld", ova16, 0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
